pipe_skid_stage: RTL
====================

# pipe_skid_stage

Parametrised pipeline buffer register that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB struct registers with one generic stage. It carries a DATA_W-bit payload between two pipeline stages using a valid/ready handshake and a two-entry skid buffer. It supports synchronous flush with bubble insertion and counts completed transfers. One instance sits between each pair of pipeline stages, with the payload being the packed stage struct.

## Interface
- DATA_W, default 32, payload width; instantiated with the bit width of the stage struct.
- RESET_VAL, default '0, payload value loaded on reset/flush (bubble); e.g. NOP-encoded struct.
- CNT_W, default 16, width of transfer counter.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; empties stage, inserts bubble.
- in_valid  in  1  upstream offers payload.
- in_ready  out  1  stage can accept; depends only on state flops.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main register holds valid payload.
- out_ready  in  1  downstream accepts; low = stall.
- out_data  out  DATA_W  main register contents.
- occupancy  out  2  entries held (0, 1, 2).
- xfer_count  out  CNT_W  completed output transfers, wraps.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (0 entries), FULL (main valid), SKID (main + skid valid).
- in_ready = (state != SKID); out_valid = (state != EMPTY); occupancy = 0/1/2 per state.
- EMPTY: in_fire -> FULL, main <= in_data.
- FULL: in_fire & out_fire -> FULL, main <= in_data. in_fire only -> SKID, skid <= in_data. out_fire only -> EMPTY, main <= RESET_VAL.
- SKID: out_fire -> FULL, main <= skid, skid <= RESET_VAL; otherwise hold.
- flush_i overrides all transitions: next state EMPTY, main and skid <= RESET_VAL. An in_fire in the same cycle is discarded.
- An out_fire in the flush cycle is a completed transfer and is counted; downstream owns its own flush.
- xfer_count += 1 on every out_fire, modulo 2^CNT_W. It is cleared only by reset.
- Payload is opaque; no field is interpreted.

## Timing
- Reset (rst_n low, asynchronous): state EMPTY, out_valid 0, in_ready 1, occupancy 0, out_data RESET_VAL, skid RESET_VAL, xfer_count 0.
- Reset mid-transfer drops both entries immediately. The first in_fire is possible in the first cycle after rst_n is released.
- Latency: in_fire at edge N -> out_valid and out_data at N+1.
- Throughput: one transfer per cycle with out_ready held high.
- No combinational path from out_ready to in_ready. in_ready falls the cycle after the stall is captured, and the skid entry absorbs the in-flight payload.
- out_data is stable while out_valid & !out_ready.
- Counter wrap: at all-ones, out_fire -> 0 with no flag.

## Structure
- The shared package pipe_buf_pkg holds the state enum (EMPTY, FULL, SKID) and the existing stage struct typedefs. Instances use $bits(stage_t) for DATA_W and a NOP-filled constant for RESET_VAL.
- Optional sub-module pipe_xfer_counter (CNT_W wrap counter with enable). All other logic stays in a single module.

## Test plan
- Reset: assert rst_n low mid-SKID -> immediately out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL, xfer_count=0.
- Streaming: in_data 1,2,3,4 on consecutive cycles with out_ready=1 -> out_data 1,2,3,4 one cycle later, each valid for one cycle, xfer_count=4.
- Stall/skid: accept A, then drop out_ready while B is offered -> occupancy=2, in_ready=0, out_data=A held. Raise out_ready -> A then B out, no loss or duplication.
- Flush: in SKID with in_valid=1 (C) and flush_i=1 -> next cycle EMPTY, out_data=RESET_VAL, C never appears at the output.
- Flush with out_fire in the same cycle -> xfer_count increments by 1, stage empty afterwards.
- Wrap: CNT_W=4, 17 transfers -> xfer_count=1.

Source files
------------

// File: rtl/pipe_buf_pkg.sv
// Shared pipeline-buffer types: skid-stage state encoding, stage payload structs
// and the NOP encoding used to fill bubbles.
package pipe_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } buf_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        regWrite;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] aluResult;
    logic [31:0] storeData;
    logic [4:0]  rd;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        regWrite;
  } mem_wb_t;

  function automatic logic [1:0] occupancyOf(input buf_state_e state);
    case (state)
      FULL:    occupancyOf = 2'd1;
      SKID:    occupancyOf = 2'd2;
      default: occupancyOf = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_xfer_counter.sv
// Free-running wrap-around event counter; cleared only by reset.
module pipe_xfer_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic valid/ready pipeline register with a two-entry skid buffer, synchronous
// flush with bubble insertion, and a completed-transfer counter.
module pipe_skid_stage
  import pipe_buf_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  xfer_count
);

  buf_state_e        r_state;
  buf_state_e        w_stateNext;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_mainNext;
  logic [DATA_W-1:0] w_skidNext;
  logic              w_inFire;
  logic              w_outFire;

  // in_ready comes from the state flop only, so out_ready never reaches it combinationally.
  assign in_ready  = (r_state != SKID);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;
  assign occupancy = occupancyOf(r_state);

  assign w_inFire  = in_valid & in_ready;
  assign w_outFire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_main  <= RESET_VAL;
      r_skid  <= RESET_VAL;
    end else begin
      r_state <= w_stateNext;
      r_main  <= w_mainNext;
      r_skid  <= w_skidNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_mainNext  = r_main;
    w_skidNext  = r_skid;
    if (flush_i) begin
      w_stateNext = EMPTY;
      w_mainNext  = RESET_VAL;
      w_skidNext  = RESET_VAL;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inFire) begin
            w_stateNext = FULL;
            w_mainNext  = in_data;
          end
        end
        FULL: begin
          if (w_inFire && w_outFire) begin
            w_mainNext = in_data;
          end else if (w_inFire) begin
            w_stateNext = SKID;
            w_skidNext  = in_data;
          end else if (w_outFire) begin
            w_stateNext = EMPTY;
            w_mainNext  = RESET_VAL;
          end
        end
        SKID: begin
          if (w_outFire) begin
            w_stateNext = FULL;
            w_mainNext  = r_skid;
            w_skidNext  = RESET_VAL;
          end
        end
        default: begin
          w_stateNext = EMPTY;
          w_mainNext  = RESET_VAL;
          w_skidNext  = RESET_VAL;
        end
      endcase
    end
  end

  // A transfer completing in a flush cycle still counts; downstream handles its own flush.
  pipe_xfer_counter #(
    .CNT_W(CNT_W)
  ) u_xferCounter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_outFire),
    .o_count(xfer_count)
  );

endmodule
